// File: rtl/alu_issue_queue.sv
// Command FIFO and registered result stage sitting in front of the 4-bit ALU.
// Optional registered zero flag (out_zero) is enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_carry,
  output logic [2:0]       out_op,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t             entry_q [DEPTH];
  cmd_t             wr_cmd_d;
  cmd_t             head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic [2:0]       out_op_q, out_op_d;

  logic             fifo_empty;
  logic             push;
  logic             issue;

  assign fifo_empty = (count_q == '0);
  // Full check deliberately ignores a same-cycle pop so in_ready depends only on state.
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign issue      = !fifo_empty && (!out_valid_q || out_ready);
  assign head       = entry_q[rd_ptr_q];

  always_comb begin
    wr_cmd_d    = '0;
    wr_cmd_d.op = in_op;
    wr_cmd_d.a  = in_a;
    wr_cmd_d.b  = in_b;
  end

  // Storage carries no reset: contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[wr_ptr_q] <= wr_cmd_d;
    end
  end

  // An idle ALU is fed opcode 111 so its result settles to zero.
  always_comb begin
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_sel = 3'b111;
    if (!fifo_empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.op;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_op_d     = out_op_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_carry_d  = alu_carry;
      out_op_d     = head.op;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= 4'd0;
      out_carry_q  <= 1'b0;
      out_op_q     <= 3'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_op_q     <= out_op_d;
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic out_zero_q, out_zero_d;

  always_comb begin
    out_zero_d = out_zero_q;
    if (issue) begin
      out_zero_d = (alu_result == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_zero_q <= 1'b0;
    end else begin
      out_zero_q <= out_zero_d;
    end
  end

  assign out_zero = out_zero_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_op     = out_op_q;
  assign count      = count_q;

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream issue stage for the 4-bit ALU (alu_4bit).
- Buffers operation commands (opcode, A, B) arriving on a valid/ready interface in a small FIFO.
- Drives the ALU's A, B and ALU_Sel inputs from the FIFO head, then registers the ALU's Result and Carry into an output stage with its own valid/ready handshake.
- Decouples command producers from result consumers across back-pressure.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  command present
- in_ready  output  1  queue can accept a command
- in_op  input  3  ALU operation select
- in_a  input  4  operand A
- in_b  input  4  operand B
- alu_a  output  4  to ALU A
- alu_b  output  4  to ALU B
- alu_sel  output  3  to ALU ALU_Sel
- alu_result  input  4  from ALU Result
- alu_carry  input  1  from ALU Carry
- out_valid  output  1  registered result present
- out_ready  input  1  consumer takes result
- out_result  output  4  registered result
- out_carry  output  1  registered carry/borrow
- out_op  output  3  opcode that produced out_result
- count  output  CNT_W  FIFO occupancy; excludes the output register

Behaviour:
- Reset (rst_n low at a clock edge): count=0, in_ready=1, out_valid=0, out_result=0, out_carry=0, out_op=0. FIFO pointers return to 0.
- Reset mid-operation flushes all queued commands and any held result; stored entry contents are don't-care.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH); it is not granted a same-cycle pop credit.
- ALU drive:
  - FIFO non-empty: alu_a/alu_b/alu_sel come combinationally from the head entry.
  - FIFO empty: alu_a=0, alu_b=0, alu_sel=3'b111, giving a zero result.
- Issue (pop): occurs when FIFO is non-empty && (!out_valid || out_ready). On that edge:
  - out_result <= alu_result, out_carry <= alu_carry, out_op <= head opcode, out_valid <= 1.
  - Head pointer advances.
- Output drain: if out_valid && out_ready with no issue that cycle, out_valid <= 0; the data registers hold their value.
- Hold: while out_valid && !out_ready, out_result, out_carry and out_op are stable.
- Latency:
  - A command pushed at edge N is issued no earlier than edge N+1.
  - out_valid is first high in the cycle after edge N+1.
  - No combinational path from in_* to out_*.
- Throughput: one command per cycle sustained when out_ready is held high.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Opcodes 101–111 pass through unchanged; the ALU returns 0/0 and the result is still delivered.
- Order: results leave in exactly command order, with no drops or duplicates.

Optional Feature:
- Macro: ALU_ISSUE_ZERO_FLAG_EN
- Defined:
  - Adds output port out_zero (1 bit), registered alongside out_result.
  - out_zero <= (alu_result == 0) at issue; reset value 0.
  - Held under back-pressure like the other output registers.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push op=000 A=9 B=8 with out_ready=1 -> one cycle later out_valid=1, out_result=4'h1, out_carry=1, out_op=000.
- Push op=001 A=3 B=5 -> out_result=4'hE, out_carry=1. Push op=100 A=A B=5 -> out_result=4'hF, out_carry=0.
- out_ready=0, push continuously:
  - Exactly DEPTH+1 (5) commands are accepted.
  - in_ready=0 with count=4.
  - Output stays frozen on the first result.
  - Then out_ready=1 -> five results drain in order and in_ready returns high.
- Streaming: 16 back-to-back random commands with out_ready=1 -> one result per cycle, matching a reference ALU model, count never exceeds 1.
- Invalid op=110 A=F B=F -> out_result=0, out_carry=0, out_op=110. With ALU_ISSUE_ZERO_FLAG_EN defined -> out_zero=1.
- Fill 3 entries plus a held output, assert rst_n=0 for one edge -> count=0, out_valid=0, in_ready=1, no stale result appears afterwards.
